unidad_riesgos: RTL and testbench
=================================

UNIDAD_RIESGOS -- requirements
Module: unidad_riesgos

Interface
REQ-001 Parameter FLUSH_CYC, default 1, number of cycles the fetch stage is squashed after a taken branch (legal range 1..7).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 id_rs  in  5  rs field of the instruction in ID.
REQ-006 id_rt  in  5  rt field of the instruction in ID.
REQ-007 id_usa_rt  in  1  ID instruction reads rt as a source.
REQ-008 ex_memread  in  1  MemRead bit of the M control group held in the ID/EX buffer.
REQ-009 ex_rt  in  5  load destination register held in the ID/EX buffer.
REQ-010 br_taken  in  1  branch resolved taken, from the EX/MEM buffer.
REQ-011 mem_wait  in  1  data memory not ready; the whole pipeline holds.
REQ-012 pc_en  out  1  PC update enable.
REQ-013 ifid_en / ifid_flush  out  1 each  IF/ID load enable / load-zero.
REQ-014 idex_en / idex_bubble  out  1 each  ID/EX load enable / force WB, M and EX control groups to zero.
REQ-015 exmem_flush  out  1  zero the EX/MEM control groups.
REQ-016 pipe_en  out  1  load enable for EX/MEM and MEM/WB.
REQ-017 estado  out  2  current FSM state.
REQ-018 cnt_stall / cnt_flush  out  CNT_W each  performance counters.

Function
REQ-019 The FSM SHALL have states RUN, FLUSH and HOLD; the control outputs are combinational from state and inputs.
REQ-020 load_use SHALL be ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_usa_rt && ex_rt==id_rt)).
REQ-021 Priority in RUN SHALL be mem_wait > br_taken > load_use.
REQ-022 RUN, no event: pc_en=ifid_en=idex_en=pipe_en=1; ifid_flush=idex_bubble=exmem_flush=0.
REQ-023 RUN + mem_wait: all enables=0, all flush/bubble=0; next state HOLD with ret=RUN saved.
REQ-024 RUN + br_taken: pc_en=1, ifid_flush=1, idex_bubble=1, exmem_flush=1, pipe_en=1; cnt_flush+1. If FLUSH_CYC=1, next state is RUN; otherwise next state is FLUSH with rem=FLUSH_CYC-1.
REQ-025 RUN + load_use: pc_en=0, ifid_en=0, idex_bubble=1, pipe_en=1; cnt_stall+1; state stays RUN, so the stall lasts exactly 1 cycle.
REQ-026 FLUSH: pc_en=1, ifid_flush=1, others as in RUN; rem decrements; on rem==1 next state is RUN; load_use and br_taken are ignored.
REQ-027 FLUSH + mem_wait: HOLD outputs per REQ-023; rem is frozen; ret=FLUSH is saved.
REQ-028 HOLD: all enables=0, no flush; br_taken and load_use are ignored; on mem_wait=0, return to ret the next cycle, where br_taken and load_use are evaluated again.
REQ-029 Counters SHALL saturate at all-ones and never wrap.

Reset
REQ-030 On rst: state=RUN, ret=RUN, rem=0, cnt_stall=cnt_flush=0.
REQ-031 While rst=1: all enables=0, all flush/bubble=0; a mid-flush or mid-hold reset abandons the operation.

Structure
REQ-032 Package riesgos_pkg SHALL hold the state encoding (RUN=0, FLUSH=1, HOLD=2) and the register-index width constant (5).
REQ-033 Sub-module contador_sat (saturating counter: enable, CNT_W) SHALL be instantiated twice.

Verification
REQ-034 ex_memread=1, ex_rt=5, id_rs=5 -> 1 cycle of pc_en=0, ifid_en=0, idex_bubble=1; cnt_stall=1.
REQ-035 Same as REQ-034 with ex_rt=0 -> no stall; same with id_rt=5, id_usa_rt=0 -> no stall.
REQ-036 FLUSH_CYC=3, br_taken pulse -> ifid_flush high for 3 cycles, exmem_flush for 1 cycle, cnt_flush=1.
REQ-037 FLUSH_CYC=3, mem_wait=1 for 4 cycles in the 2nd flush cycle -> HOLD for 4 cycles, then 2 more flush cycles.
REQ-038 br_taken, load_use and mem_wait in the same cycle -> HOLD; after release, the branch flush wins; cnt_stall unchanged.
REQ-039 Force cnt_stall to 0xFFFE, then 3 stalls -> value stays 0xFFFF; rst pulse mid-FLUSH -> estado=RUN and counters 0 immediately.

Source files
------------

// File: rtl/riesgos_pkg.sv
// riesgos_pkg -- shared state encoding and field widths for the hazard unit | rev 1.0
`default_nettype none

package riesgos_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HOLD  = 2'd2
   } estado_t;

endpackage

`default_nettype wire

// File: rtl/contador_sat.sv
// contador_sat -- enabled up-counter that sticks at all-ones | rev 1.0
`default_nettype none

module contador_sat #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (en && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/unidad_riesgos.sv
// unidad_riesgos -- pipeline hazard unit: load-use stall, branch squash, memory hold | rev 1.0
`default_nettype none

import riesgos_pkg::*;

module unidad_riesgos #(
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_usa_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             br_taken,
   input  logic             mem_wait,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic             pipe_en,
   output logic [1:0]       estado,
   output logic [CNT_W-1:0] cnt_stall,
   output logic [CNT_W-1:0] cnt_flush
);

   localparam logic [2:0] REM_INI = 3'(FLUSH_CYC - 1);

   estado_t    state_q, state_n;
   estado_t    ret_q,   ret_n;
   logic [2:0] rem_q,   rem_n;
   logic       load_use;
   logic       inc_stall;
   logic       inc_flush;

   assign load_use = ex_memread && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_usa_rt && (ex_rt == id_rt)));

   assign estado = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         ret_q   <= RUN;
         rem_q   <= '0;
      end else begin
         state_q <= state_n;
         ret_q   <= ret_n;
         rem_q   <= rem_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      ret_n       = ret_q;
      rem_n       = rem_q;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      pipe_en     = 1'b0;
      inc_stall   = 1'b0;
      inc_flush   = 1'b0;

      // Outputs stay quiet during reset so no stage captures garbage.
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (mem_wait) begin
                  state_n = HOLD;
                  ret_n   = RUN;
               end else if (br_taken) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_en     = 1'b1;
                  idex_bubble = 1'b1;
                  exmem_flush = 1'b1;
                  pipe_en     = 1'b1;
                  inc_flush   = 1'b1;
                  if (FLUSH_CYC > 1) begin
                     state_n = FLUSH;
                     rem_n   = REM_INI;
                  end
               end else if (load_use) begin
                  idex_en     = 1'b1;
                  idex_bubble = 1'b1;
                  pipe_en     = 1'b1;
                  inc_stall   = 1'b1;
               end else begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
                  idex_en = 1'b1;
                  pipe_en = 1'b1;
               end
            end
            FLUSH: begin
               if (mem_wait) begin
                  state_n = HOLD;
                  ret_n   = FLUSH;
               end else begin
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_en    = 1'b1;
                  pipe_en    = 1'b1;
                  rem_n      = rem_q - 3'd1;
                  if (rem_q == 3'd1) begin
                     state_n = RUN;
                  end
               end
            end
            HOLD: begin
               if (!mem_wait) begin
                  state_n = ret_q;
               end
            end
            default: begin
               state_n = RUN;
            end
         endcase
      end
   end

   contador_sat #(.CNT_W(CNT_W)) u_cnt_stall (
      .clk (clk),
      .rst (rst),
      .en  (inc_stall),
      .cnt (cnt_stall)
   );

   contador_sat #(.CNT_W(CNT_W)) u_cnt_flush (
      .clk (clk),
      .rst (rst),
      .en  (inc_flush),
      .cnt (cnt_flush)
   );

endmodule

`default_nettype wire

// File: tb/tb_unidad_riesgos.sv
// tb_unidad_riesgos -- directed checks of the hazard unit (3-cycle and 1-cycle flush variants)
`default_nettype none

module tb_unidad_riesgos;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_usa_rt, ex_memread, br_taken, mem_wait;

   logic        pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_bubble3, exmem_flush3, pipe_en3;
   logic [1:0]  estado3;
   logic [15:0] cnt_stall3, cnt_flush3;

   logic        pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_flush1, pipe_en1;
   logic [1:0]  estado1;
   logic [3:0]  cnt_stall1, cnt_flush1;

   int vectors = 0;
   int errs    = 0;

   // control vector order: pc_en ifid_en ifid_flush idex_en idex_bubble exmem_flush pipe_en
   localparam logic [6:0] C_RUN   = 7'b1101001;
   localparam logic [6:0] C_ZERO  = 7'b0000000;
   localparam logic [6:0] C_FLUSH = 7'b1111001;
   localparam logic [6:0] C_BR    = 7'b1010111;
   localparam logic [6:0] M_BR    = 7'b1010111;
   localparam logic [6:0] C_LU    = 7'b0000101;
   localparam logic [6:0] M_LU    = 7'b1110111;
   localparam logic [6:0] M_ALL   = 7'b1111111;

   always #5 clk = ~clk;

   unidad_riesgos #(.FLUSH_CYC(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usa_rt(id_usa_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .mem_wait(mem_wait),
      .pc_en(pc_en3), .ifid_en(ifid_en3), .ifid_flush(ifid_flush3), .idex_en(idex_en3),
      .idex_bubble(idex_bubble3), .exmem_flush(exmem_flush3), .pipe_en(pipe_en3),
      .estado(estado3), .cnt_stall(cnt_stall3), .cnt_flush(cnt_flush3)
   );

   unidad_riesgos #(.FLUSH_CYC(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usa_rt(id_usa_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .mem_wait(mem_wait),
      .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1), .idex_en(idex_en1),
      .idex_bubble(idex_bubble1), .exmem_flush(exmem_flush1), .pipe_en(pipe_en1),
      .estado(estado1), .cnt_stall(cnt_stall1), .cnt_flush(cnt_flush1)
   );

   wire [6:0] ctl3 = {pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_bubble3, exmem_flush3, pipe_en3};
   wire [6:0] ctl1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_flush1, pipe_en1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [6:0] obs, input logic [6:0] exp,
                          input logic [6:0] mask);
      chk(tag, {25'd0, obs & mask}, {25'd0, exp & mask});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_in();
      id_rs = 5'd0; id_rt = 5'd0; id_usa_rt = 1'b0;
      ex_memread = 1'b0; ex_rt = 5'd0; br_taken = 1'b0; mem_wait = 1'b0;
   endtask

   task automatic set_lu();
      ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      settle();
      chk_ctl("rst_ctl", ctl3, C_ZERO, M_ALL);
      chk("rst_estado", {30'd0, estado3}, 32'd0);
      chk("rst_cnt_stall", {16'd0, cnt_stall3}, 32'd0);
      chk("rst_cnt_flush", {16'd0, cnt_flush3}, 32'd0);
      tick(); tick();
      rst = 1'b0;
      settle();
      chk_ctl("idle_ctl", ctl3, C_RUN, M_ALL);
      chk_ctl("idle_ctl1", ctl1, C_RUN, M_ALL);

      // single-cycle load-use stall on rs
      set_lu();
      settle();
      chk_ctl("lu_rs_ctl", ctl3, C_LU, M_LU);
      tick();
      clear_in();
      settle();
      chk_ctl("lu_after_ctl", ctl3, C_RUN, M_ALL);
      chk("lu_cnt_stall", {16'd0, cnt_stall3}, 32'd1);
      chk("lu_cnt_stall1", {28'd0, cnt_stall1}, 32'd1);

      // no stall on $zero or when rt is not a source
      ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      settle();
      chk_ctl("lu_zero_ctl", ctl3, C_RUN, M_ALL);
      tick();
      clear_in();
      ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd2; id_rt = 5'd5; id_usa_rt = 1'b0;
      settle();
      chk_ctl("lu_rt_unused_ctl", ctl3, C_RUN, M_ALL);
      tick();
      id_usa_rt = 1'b1;
      settle();
      chk_ctl("lu_rt_used_ctl", ctl3, C_LU, M_LU);
      tick();
      clear_in();
      settle();
      chk("lu_rt_cnt_stall", {16'd0, cnt_stall3}, 32'd2);

      // branch: 3-cycle squash on dut3, 1-cycle on dut1
      br_taken = 1'b1;
      settle();
      chk_ctl("br_ctl", ctl3, C_BR, M_BR);
      chk_ctl("br_ctl1", ctl1, C_BR, M_BR);
      tick();
      br_taken = 1'b0;
      settle();
      chk("br_f1_estado", {30'd0, estado3}, 32'd1);
      chk_ctl("br_f1_ctl", ctl3, C_FLUSH, M_ALL);
      chk("br_cnt_flush", {16'd0, cnt_flush3}, 32'd1);
      chk("br1_estado", {30'd0, estado1}, 32'd0);
      chk_ctl("br1_after_ctl", ctl1, C_RUN, M_ALL);
      chk("br1_cnt_flush", {28'd0, cnt_flush1}, 32'd1);
      tick();
      set_lu();
      settle();
      chk_ctl("br_f2_lu_ignored", ctl3, C_FLUSH, M_ALL);
      tick();
      clear_in();
      br_taken = 1'b1;
      settle();
      chk("br_f3_estado", {30'd0, estado3}, 32'd0);
      chk_ctl("br_f3_br_taken_run", ctl3, C_BR, M_BR);
      tick();
      clear_in();
      tick(); tick();
      settle();
      chk("br_done_estado", {30'd0, estado3}, 32'd0);
      chk_ctl("br_done_ctl", ctl3, C_RUN, M_ALL);
      chk("br_cnt_stall_keep", {16'd0, cnt_stall3}, 32'd2);
      chk("br_cnt_flush2", {16'd0, cnt_flush3}, 32'd2);

      // mem_wait for 4 cycles in the second flush cycle
      br_taken = 1'b1;
      settle();
      tick();
      br_taken = 1'b0;
      mem_wait = 1'b1;
      settle();
      chk("mw_c1_estado", {30'd0, estado3}, 32'd1);
      chk_ctl("mw_c1_ctl", ctl3, C_ZERO, M_ALL);
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         chk("mw_hold_estado", {30'd0, estado3}, 32'd2);
         chk_ctl("mw_hold_ctl", ctl3, C_ZERO, M_ALL);
      end
      tick();
      mem_wait = 1'b0;
      settle();
      chk("mw_hold4_estado", {30'd0, estado3}, 32'd2);
      tick();
      settle();
      chk("mw_f_a_estado", {30'd0, estado3}, 32'd1);
      chk_ctl("mw_f_a_ctl", ctl3, C_FLUSH, M_ALL);
      tick();
      settle();
      chk("mw_f_b_estado", {30'd0, estado3}, 32'd1);
      chk_ctl("mw_f_b_ctl", ctl3, C_FLUSH, M_ALL);
      tick();
      settle();
      chk("mw_run_estado", {30'd0, estado3}, 32'd0);
      chk("mw_cnt_flush", {16'd0, cnt_flush3}, 32'd3);

      // all three events together: hold first, then the branch wins
      br_taken = 1'b1; mem_wait = 1'b1;
      set_lu();
      settle();
      chk_ctl("all3_ctl", ctl3, C_ZERO, M_ALL);
      tick();
      mem_wait = 1'b0;
      settle();
      chk("all3_hold_estado", {30'd0, estado3}, 32'd2);
      chk_ctl("all3_hold_ctl", ctl3, C_ZERO, M_ALL);
      tick();
      settle();
      chk("all3_ret_estado", {30'd0, estado3}, 32'd0);
      chk_ctl("all3_ret_ctl", ctl3, C_BR, M_BR);
      tick();
      clear_in();
      settle();
      chk("all3_flush_estado", {30'd0, estado3}, 32'd1);
      chk("all3_cnt_stall", {16'd0, cnt_stall3}, 32'd2);
      chk("all3_cnt_flush", {16'd0, cnt_flush3}, 32'd4);

      // asynchronous reset in the middle of a flush
      rst = 1'b1;
      settle();
      chk("rst_mid_estado", {30'd0, estado3}, 32'd0);
      chk("rst_mid_cnt_stall", {16'd0, cnt_stall3}, 32'd0);
      chk("rst_mid_cnt_flush", {16'd0, cnt_flush3}, 32'd0);
      chk_ctl("rst_mid_ctl", ctl3, C_ZERO, M_ALL);
      tick();
      rst = 1'b0;
      settle();
      chk_ctl("rst_mid_after_ctl", ctl3, C_RUN, M_ALL);

      // saturation: continuous stalls up to 0xFFFE, then 3 more
      set_lu();
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", {16'd0, cnt_stall3}, 32'h0000FFFE);
      chk("sat1_cnt_stall", {28'd0, cnt_stall1}, 32'hF);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_ffff", {16'd0, cnt_stall3}, 32'h0000FFFF);
      chk_ctl("sat_still_stall", ctl3, C_LU, M_LU);
      clear_in();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

`default_nettype wire
